length_counter_bank: RTL and testbench

- Parametrised multi-channel successor to the single APU length counter.
- Holds NUM_CH independent length counters: pulse 1, pulse 2, triangle and noise by default.
- Shares one half-frame clock and one write port, exports a per-channel non-zero vector for $4015 reads and channel gating, and flags expirations.
- Sits between the APU register-write decode, the frame counter and the channel units.

---
 rtl/apu_pkg.sv | 20 ++
 rtl/length_counter_ch.sv | 59 +++++
 rtl/length_counter_bank.sv | 50 +++++
 tb/tb_length_counter_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU length-counter definitions: the 32-entry length table and its lookup.
package apu_pkg;

  localparam int unsigned LEN_W = 8;

  typedef logic [4:0] len_idx_t;

  localparam logic [LEN_W-1:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  // Returns the 8-bit table entry; callers zero-extend to their counter width.
  function automatic logic [LEN_W-1:0] len_lookup(input len_idx_t idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/length_counter_ch.sv
// One APU length-counter channel: count/expired registers and the update priority.
// Optional hardware reload quirk selected by LC_RELOAD_QUIRK_EN.
module length_counter_ch
  import apu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clk_en,
  input  logic     half_frame,
  input  logic     load,
  input  len_idx_t load_idx,
  input  logic     halt,
  input  logic     enable,
  output logic     non_zero,
  output logic     expired
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             dec_fire;
  logic             load_take;
  logic             rule3;

  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    dec_fire  = 1'b0;
    load_take = load;
    rule3     = 1'b0;
    if (clk_en) begin
      dec_fire = half_frame && !halt && (count_q != '0);
`ifdef LC_RELOAD_QUIRK_EN
      // A reload coinciding with a live decrement is lost on real hardware.
      if (dec_fire) load_take = 1'b0;
`endif
      rule3 = enable && !load_take && dec_fire;
      if (!enable)        count_d = '0;
      else if (load_take) count_d = CNT_W'(len_lookup(load_idx));
      else if (dec_fire)  count_d = count_q - CNT_W'(1);
      expired_d = rule3 && (count_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign non_zero = (count_q != '0);
  assign expired  = expired_q;

endmodule

// File: rtl/length_counter_bank.sv
// Bank of NUM_CH APU length counters sharing one write port and half-frame tick.
// Optional reload quirk: define LC_RELOAD_QUIRK_EN.
module length_counter_bank
  import apu_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              half_frame,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [4:0]        load_idx,
  input  logic [NUM_CH-1:0] halt,
  input  logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] non_zero,
  output logic [NUM_CH-1:0] expired
);

  logic [NUM_CH-1:0] ch_load;

  // Selects beyond NUM_CH-1 match no channel, so such loads vanish.
  always_comb begin
    ch_load = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (load && (load_ch == CH_W'(i))) ch_load[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    length_counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .half_frame (half_frame),
      .load       (ch_load[g]),
      .load_idx   (len_idx_t'(load_idx)),
      .halt       (halt[g]),
      .enable     (enable[g]),
      .non_zero   (non_zero[g]),
      .expired    (expired[g])
    );
  end

endmodule

// File: tb/tb_length_counter_bank.sv
// Directed self-checking bench for length_counter_bank (4-, 2- and 3-channel builds).
module tb_length_counter_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       clk_en = 1'b1, half_frame = 1'b0, load = 1'b0;
  logic [1:0] load_ch = '0;
  logic [4:0] load_idx = '0;
  logic [3:0] halt = '0, enable = '0;
  logic [3:0] non_zero, expired;

  // 2-channel instance
  logic       clk_en_b = 1'b1, half_frame_b = 1'b0, load_b = 1'b0;
  logic [0:0] load_ch_b = '0;
  logic [4:0] load_idx_b = '0;
  logic [1:0] halt_b = '0, enable_b = '0;
  logic [1:0] non_zero_b, expired_b;

  // 3-channel instance
  logic       clk_en_c = 1'b1, half_frame_c = 1'b0, load_c = 1'b0;
  logic [1:0] load_ch_c = '0;
  logic [4:0] load_idx_c = '0;
  logic [2:0] halt_c = '0, enable_c = '0;
  logic [2:0] non_zero_c, expired_c;

  int tests = 0;
  int failed = 0;

  length_counter_bank #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .half_frame(half_frame),
    .load(load), .load_ch(load_ch), .load_idx(load_idx), .halt(halt),
    .enable(enable), .non_zero(non_zero), .expired(expired)
  );

  length_counter_bank #(.NUM_CH(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en_b), .half_frame(half_frame_b),
    .load(load_b), .load_ch(load_ch_b), .load_idx(load_idx_b), .halt(halt_b),
    .enable(enable_b), .non_zero(non_zero_b), .expired(expired_b)
  );

  length_counter_bank #(.NUM_CH(3), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .clk_en(clk_en_c), .half_frame(half_frame_c),
    .load(load_c), .load_ch(load_ch_c), .load_idx(load_idx_c), .halt(halt_c),
    .enable(enable_c), .non_zero(non_zero_c), .expired(expired_c)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_nz, exp_ex;

    // Reset
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rst_nz", 8'(non_zero), 8'h0);
    chk("rst_ex", 8'(expired), 8'h0);

    // ch2 loaded with 2, two ticks to expire
    enable = 4'hF;
    load = 1'b1; load_ch = 2'd2; load_idx = 5'h03;
    cyc();
    load = 1'b0;
    chk("ld2_nz", 8'(non_zero), 8'h4);
    half_frame = 1'b1;
    cyc();
    chk("dec2_nz", 8'(non_zero), 8'h4);
    chk("dec2_ex", 8'(expired), 8'h0);
    cyc();
    chk("exp2_nz", 8'(non_zero), 8'h0);
    chk("exp2_ex", 8'(expired), 8'h4);
    half_frame = 1'b0;
    cyc();
    chk("exp2_clr", 8'(expired), 8'h0);

    // ch0 loaded with 254, halted for 10 ticks, then counts down fully
    load = 1'b1; load_ch = 2'd0; load_idx = 5'h01; halt = 4'b0001;
    cyc();
    load = 1'b0; half_frame = 1'b1;
    cyc(10);
    chk("halt0_nz", 8'(non_zero), 8'h1);
    chk("halt0_ex", 8'(expired), 8'h0);
    halt = 4'b0000;
    cyc(253);
    chk("cnt0_1_nz", 8'(non_zero), 8'h1);
    chk("cnt0_1_ex", 8'(expired), 8'h0);
    cyc();
    chk("exp0_nz", 8'(non_zero), 8'h0);
    chk("exp0_ex", 8'(expired), 8'h1);
    cyc();
    chk("exp0_once", 8'(expired), 8'h0);
    cyc(3);
    chk("nowrap0_nz", 8'(non_zero), 8'h0);
    chk("nowrap0_ex", 8'(expired), 8'h0);
    half_frame = 1'b0;

    // ch1 loaded with 192, then disabled; load while disabled is dropped
    load = 1'b1; load_ch = 2'd1; load_idx = 5'h18;
    cyc();
    load = 1'b0;
    chk("ld1_nz", 8'(non_zero), 8'h2);
    enable = 4'b1101;
    cyc();
    chk("dis1_nz", 8'(non_zero), 8'h0);
    chk("dis1_ex", 8'(expired), 8'h0);
    load = 1'b1; load_ch = 2'd1; load_idx = 5'h03;
    cyc();
    load = 1'b0;
    chk("lddis1_nz", 8'(non_zero), 8'h0);
    enable = 4'hF;

    // ch3 count 10, reload coincident with a tick
    load = 1'b1; load_ch = 2'd3; load_idx = 5'h00;
    cyc();
    half_frame = 1'b1;
    cyc();
    load = 1'b0;
    cyc(9);
`ifdef LC_RELOAD_QUIRK_EN
    exp_nz = 4'b0000; exp_ex = 4'b1000;
`else
    exp_nz = 4'b1000; exp_ex = 4'b0000;
`endif
    chk("coinc3_nz", 8'(exp_nz) ^ 8'(non_zero) ^ 8'(exp_nz), 8'(exp_nz));
    chk("coinc3_ex", 8'(expired), 8'(exp_ex));
    cyc(2);
    chk("drain3_nz", 8'(non_zero), 8'h0);
    // Reload from zero coincident with a tick: load applies in both builds
    load = 1'b1; load_ch = 2'd3; load_idx = 5'h00;
    cyc();
    load = 1'b0;
    chk("coinc3z_nz", 8'(non_zero), 8'h8);
    cyc(9);
    chk("coinc3z_9_nz", 8'(non_zero), 8'h8);
    chk("coinc3z_9_ex", 8'(expired), 8'h0);
    cyc();
    chk("coinc3z_nz0", 8'(non_zero), 8'h0);
    chk("coinc3z_ex", 8'(expired), 8'h8);
    half_frame = 1'b0;

    // clk_en low holds everything including a pending expired pulse
    load = 1'b1; load_ch = 2'd1; load_idx = 5'h00;
    cyc();
    load_ch = 2'd2; load_idx = 5'h03;
    cyc();
    load = 1'b0; half_frame = 1'b1;
    cyc(2);
    chk("pre_en_nz", 8'(non_zero), 8'h2);
    chk("pre_en_ex", 8'(expired), 8'h4);
    clk_en = 1'b0; load = 1'b1; load_ch = 2'd1; load_idx = 5'h03;
    cyc(5);
    chk("en0_nz", 8'(non_zero), 8'h2);
    chk("en0_ex", 8'(expired), 8'h4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_en0_nz", 8'(non_zero), 8'h0);
    chk("rst_en0_ex", 8'(expired), 8'h0);
    load = 1'b0; half_frame = 1'b0; clk_en = 1'b1;

    // NUM_CH=2: channel 1 loaded with 60
    enable_b = 2'b11;
    load_b = 1'b1; load_ch_b = 1'b1; load_idx_b = 5'h0A;
    cyc();
    load_b = 1'b0;
    chk("b_ld_nz", 8'(non_zero_b), 8'h2);
    half_frame_b = 1'b1;
    cyc(59);
    chk("b_59_nz", 8'(non_zero_b), 8'h2);
    chk("b_59_ex", 8'(expired_b), 8'h0);
    cyc();
    chk("b_60_nz", 8'(non_zero_b), 8'h0);
    chk("b_60_ex", 8'(expired_b), 8'h2);
    half_frame_b = 1'b0;

    // NUM_CH=3: out-of-range select ignored, in-range select works
    enable_c = 3'b111;
    load_c = 1'b1; load_ch_c = 2'd3; load_idx_c = 5'h00;
    cyc();
    chk("c_oor_nz", 8'(non_zero_c), 8'h0);
    load_ch_c = 2'd2;
    cyc();
    load_c = 1'b0;
    chk("c_ld2_nz", 8'(non_zero_c), 8'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
